udp_reg_master: RTL and testbench
=================================

# udp_reg_master

Register-ring initiator that turns a single CPU-side register access into one request on the UDP register ring, then collects the ring's returning transaction. It sits at the head and tail of the ring, upstream of the first software/hardware register block and downstream of the last. It drops stale returns and answers with a fixed pattern when no block claims the address or the ring does not return within a bounded time.

## Interface
Parameters:
- UDP_REG_SRC_WIDTH, 2, width of the ring source-ID field.
- SRC_ADDR, 0, source ID stamped on issued requests; only returns carrying this ID are accepted.
- TIMEOUT, 127, maximum number of WAIT-cycle counter values before timeout (1..65535).
- TIMEOUT_RESULT, 32'hdead_0000, read data returned on timeout or unclaimed access.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- core_reg_req  in  1  level request from CPU side; held until core_reg_ack, then dropped.
- core_reg_rd_wr_L  in  1  1 = read, 0 = write.
- core_reg_addr  in  `UDP_REG_ADDR_WIDTH  register address (tag + block address).
- core_reg_wr_data  in  `CPCI_NF2_DATA_WIDTH  write data.
- core_reg_rd_data  out  `CPCI_NF2_DATA_WIDTH  completion data.
- core_reg_ack  out  1  completion; held high until core_reg_req goes low.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring request, ack and direction, toward the first ring block.
- reg_addr_out  out  `UDP_REG_ADDR_WIDTH  ring address.
- reg_data_out  out  `CPCI_NF2_DATA_WIDTH  ring data.
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring source ID.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring returns from the last block.
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  returned address.
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  returned data.
- reg_src_in  in  UDP_REG_SRC_WIDTH  returned source ID.

## Operation
- All outputs are registered. Reset drives every output to 0, puts the FSM in IDLE and clears the 16-bit wait counter. A request in flight is abandoned.
- FSM states: IDLE, WAIT, DONE.
- IDLE, core_reg_req=1:
  - For one cycle, drive reg_req_out=1, reg_ack_out=0, reg_rd_wr_L_out=core_reg_rd_wr_L, reg_addr_out=core_reg_addr and reg_src_out=SRC_ADDR.
  - reg_data_out=core_reg_wr_data on writes, 0 on reads.
  - Clear the counter and go to WAIT.
- Ring outputs are 0 in every cycle other than the issue cycle.
- WAIT, match (reg_req_in=1 and reg_src_in==SRC_ADDR):
  - If reg_ack_in=1, core_reg_rd_data<=reg_data_in. This applies to writes too, which echo the written data.
  - If reg_ack_in=0 (unclaimed), core_reg_rd_data<=TIMEOUT_RESULT.
  - Set core_reg_ack<=1 and go to DONE.
- WAIT, no match, counter==TIMEOUT: core_reg_rd_data<=TIMEOUT_RESULT, core_reg_ack<=1, go to DONE.
- WAIT, otherwise: counter+1.
- A match and the timeout in the same cycle: the match wins.
- Returns with a foreign reg_src_in are ignored in every state.
- Matching returns seen in IDLE or DONE are stale (late returns after a timeout) and are ignored; core_reg_rd_data is not changed.
- DONE: hold core_reg_ack=1 and core_reg_rd_data. When core_reg_req is sampled 0, set core_reg_ack<=0 and go to IDLE.
- core_reg_addr, core_reg_wr_data and core_reg_rd_wr_L are sampled only in IDLE. Changes in WAIT or DONE have no effect.

## Timing
- core_reg_req is first high in IDLE in cycle n. reg_req_out is high in cycle n+1 only, and WAIT starts in cycle n+1 with counter 0.
- Ring with round-trip latency L cycles (return visible L cycles after reg_req_out): core_reg_ack rises in cycle n+2+L. Direct combinational loopback (L=0) gives the ack in cycle n+2.
- Timeout: core_reg_ack rises in cycle n+2+TIMEOUT.
- core_reg_req is sampled low in cycle m in DONE: core_reg_ack falls in m+1. A new request is accepted no earlier than m+1.
- Throughput: at most one outstanding ring transaction.

## Test plan
- Read hit, one register-block node with 1-cycle latency, register 3 preloaded to 32'h1234_5678. Read address 3 → reg_req_out pulses for exactly 1 cycle, core_reg_ack rises at n+3, core_reg_rd_data=32'h1234_5678.
- Write 32'hcafe_f00d to address 5, then read address 5 → write acks with rd_data=32'hcafe_f00d; read returns 32'hcafe_f00d.
- Unclaimed address (node tag mismatch, returns with reg_ack_in=0) → ack at n+3, rd_data=32'hdead_0000.
- Broken ring (reg_req_in tied 0), TIMEOUT=10 → ack at n+12, rd_data=32'hdead_0000. A matching return injected 5 cycles later is ignored; the next read still returns correct data.
- Foreign source: inject reg_req_in=1, reg_src_in=SRC_ADDR+1, reg_ack_in=1 during WAIT → no ack; the true return 3 cycles later completes normally. Also inject a matching return and the timeout in the same cycle → returned data wins.
- Reset asserted mid-WAIT → all outputs 0 the next cycle. A late return after reset is ignored, and the next request completes normally. Hold core_reg_req high 4 cycles past ack → core_reg_ack stays high and reg_req_out stays 0 until req drops.

Source files
------------

// File: rtl/udp_reg_master.sv
// rtl/udp_reg_master.sv - single-outstanding CPU-to-register-ring initiator
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_master #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ADDR = 0,
  parameter int TIMEOUT = 127,
  parameter logic [`CPCI_NF2_DATA_WIDTH-1:0] TIMEOUT_RESULT = 32'hdead_0000
) (
  input  logic                             clk,
  input  logic                             reset,
  // CPU side
  input  logic                             core_reg_req,
  input  logic                             core_reg_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   core_reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  core_reg_wr_data,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]  core_reg_rd_data,
  output logic                             core_reg_ack,
  // ring head
  output logic                             reg_req_out,
  output logic                             reg_ack_out,
  output logic                             reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out,
  // ring tail
  input  logic                             reg_req_in,
  input  logic                             reg_ack_in,
  input  logic                             reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in
);

  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID = UDP_REG_SRC_WIDTH'(SRC_ADDR);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              ack_q, ack_d;
  logic              req_out_q, req_out_d;
  logic              ack_out_q, ack_out_d;
  logic              rd_wr_out_q, rd_wr_out_d;
  logic [AW-1:0]     addr_out_q, addr_out_d;
  logic [DW-1:0]     data_out_q, data_out_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_out_q, src_out_d;

  logic              match;

  // The returned direction and address are not needed: the source ID alone
  // identifies our single outstanding transaction.
  logic              unused_ring_bits;
  assign unused_ring_bits = ^{reg_rd_wr_L_in, reg_addr_in};

  assign match = reg_req_in && (reg_src_in == SRC_ID);

  // Next-state and output logic; ring outputs default to idle every cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    ack_d       = ack_q;
    req_out_d   = 1'b0;
    ack_out_d   = 1'b0;
    rd_wr_out_d = 1'b0;
    addr_out_d  = '0;
    data_out_d  = '0;
    src_out_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (core_reg_req) begin
          req_out_d   = 1'b1;
          rd_wr_out_d = core_reg_rd_wr_L;
          addr_out_d  = core_reg_addr;
          src_out_d   = SRC_ID;
          data_out_d  = core_reg_rd_wr_L ? '0 : core_reg_wr_data;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A matching return takes priority over an expiring timer
        if (match) begin
          rd_data_d = reg_ack_in ? reg_data_in : TIMEOUT_RESULT;
          ack_d     = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          rd_data_d = TIMEOUT_RESULT;
          ack_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        ack_d = 1'b1;
        if (!core_reg_req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any request in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      ack_q       <= 1'b0;
      req_out_q   <= 1'b0;
      ack_out_q   <= 1'b0;
      rd_wr_out_q <= 1'b0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      src_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      ack_q       <= ack_d;
      req_out_q   <= req_out_d;
      ack_out_q   <= ack_out_d;
      rd_wr_out_q <= rd_wr_out_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      src_out_q   <= src_out_d;
    end
  end

  assign core_reg_rd_data = rd_data_q;
  assign core_reg_ack     = ack_q;
  assign reg_req_out      = req_out_q;
  assign reg_ack_out      = ack_out_q;
  assign reg_rd_wr_L_out  = rd_wr_out_q;
  assign reg_addr_out     = addr_out_q;
  assign reg_data_out     = data_out_q;
  assign reg_src_out      = src_out_q;

endmodule

// File: tb/tb_udp_reg_master.sv
// tb/tb_udp_reg_master.sv - directed vector bench for udp_reg_master
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_reg_req;
  logic        core_reg_rd_wr_L;
  logic [22:0] core_reg_addr;
  logic [31:0] core_reg_wr_data;
  logic [31:0] core_reg_rd_data;
  logic        core_reg_ack;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;

  // ring node model (1-cycle latency, 16 registers at addresses 0..15)
  logic        node_req, node_ack, node_rd_wr;
  logic [22:0] node_addr;
  logic [31:0] node_data;
  logic [1:0]  node_src;
  logic [31:0] node_regs [16];

  // injection override and broken-ring control
  logic        ring_broken = 1'b0;
  logic        inj_en = 1'b0, inj_req = 1'b0, inj_ack = 1'b0;
  logic [1:0]  inj_src = 2'd0;
  logic [31:0] inj_data = 32'd0;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    logic        rd_wr_L;
    logic [22:0] addr;
    logic [31:0] wr_data;
    logic        broken;
    logic [31:0] exp_data;
    int          exp_k;
  } vec_t;

  vec_t vecs [7];

  udp_reg_master #(
    .UDP_REG_SRC_WIDTH(2),
    .SRC_ADDR(0),
    .TIMEOUT(10),
    .TIMEOUT_RESULT(32'hdead_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_reg_req(core_reg_req),
    .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr),
    .core_reg_wr_data(core_reg_wr_data),
    .core_reg_rd_data(core_reg_rd_data),
    .core_reg_ack(core_reg_ack),
    .reg_req_out(reg_req_out),
    .reg_ack_out(reg_ack_out),
    .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out),
    .reg_data_out(reg_data_out),
    .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in),
    .reg_ack_in(reg_ack_in),
    .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in),
    .reg_data_in(reg_data_in),
    .reg_src_in(reg_src_in)
  );

  always #5 clk = ~clk;

  // Register node: claims addresses below 16, echoes written data
  always @(posedge clk) begin
    if (reset) begin
      node_req   <= 1'b0;
      node_ack   <= 1'b0;
      node_rd_wr <= 1'b0;
      node_addr  <= '0;
      node_data  <= '0;
      node_src   <= '0;
      for (int i = 0; i < 16; i++) node_regs[i] <= '0;
      node_regs[3] <= 32'h1234_5678;
    end else begin
      node_req   <= reg_req_out;
      node_src   <= reg_src_out;
      node_rd_wr <= reg_rd_wr_L_out;
      node_addr  <= reg_addr_out;
      node_ack   <= 1'b0;
      node_data  <= reg_data_out;
      if (reg_req_out && reg_addr_out < 23'd16) begin
        node_ack <= 1'b1;
        if (reg_rd_wr_L_out) node_data <= node_regs[reg_addr_out[3:0]];
        else node_regs[reg_addr_out[3:0]] <= reg_data_out;
      end
    end
  end

  // Ring tail: injected return, broken ring, or the node
  always_comb begin
    reg_req_in     = ring_broken ? 1'b0 : node_req;
    reg_ack_in     = node_ack;
    reg_src_in     = node_src;
    reg_data_in    = node_data;
    reg_rd_wr_L_in = node_rd_wr;
    reg_addr_in    = node_addr;
    if (inj_en) begin
      reg_req_in  = inj_req;
      reg_ack_in  = inj_ack;
      reg_src_in  = inj_src;
      reg_data_in = inj_data;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic inject(input logic [1:0] src, input logic ack, input logic [31:0] data);
    inj_en = 1'b1; inj_req = 1'b1; inj_src = src; inj_ack = ack; inj_data = data;
  endtask

  task automatic clear_inject();
    inj_en = 1'b0; inj_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core"}, {31'd0, core_reg_ack, core_reg_rd_data}, 64'd0);
    check({tag, "_ring_ctl"}, {36'd0, reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_src_out, reg_addr_out}, 64'd0);
    check({tag, "_ring_data"}, {32'd0, reg_data_out}, 64'd0);
  endtask

  // One complete access: issue, wait for ack (bounded), release, check fall
  task automatic run_vec(input vec_t v, input string tag);
    int k, ack_k, pulses, pulse_k;
    logic [31:0] exp_issue_data;
    ring_broken = v.broken;
    exp_issue_data = v.rd_wr_L ? 32'd0 : v.wr_data;
    @(negedge clk);
    core_reg_rd_wr_L = v.rd_wr_L;
    core_reg_addr    = v.addr;
    core_reg_wr_data = v.wr_data;
    core_reg_req     = 1'b1;
    k = 0; ack_k = -1; pulses = 0; pulse_k = -1;
    while (ack_k < 0 && k < 100) begin
      tick();
      k++;
      if (reg_req_out) begin
        pulses++;
        pulse_k = k;
        check({tag, "_issue"}, {6'd0, reg_rd_wr_L_out, reg_src_out, reg_addr_out, reg_data_out},
              {6'd0, v.rd_wr_L, 2'd0, v.addr, exp_issue_data});
      end
      if (core_reg_ack) ack_k = k;
    end
    check({tag, "_ack_cycle"}, 64'(ack_k), 64'(v.exp_k));
    check({tag, "_rd_data"}, {32'd0, core_reg_rd_data}, {32'd0, v.exp_data});
    check({tag, "_req_pulses"}, {32'(pulses), 32'(pulse_k)}, {32'd1, 32'd1});
    core_reg_req = 1'b0;
    tick();
    check({tag, "_ack_fall"}, 64'(core_reg_ack), 64'd0);
    ring_broken = 1'b0;
  endtask

  initial begin
    vec_t rd3;
    vecs[0] = '{1'b1, 23'd3,  32'h0,         1'b0, 32'h1234_5678, 3};
    vecs[1] = '{1'b0, 23'd5,  32'hcafe_f00d, 1'b0, 32'hcafe_f00d, 3};
    vecs[2] = '{1'b1, 23'd5,  32'h0,         1'b0, 32'hcafe_f00d, 3};
    vecs[3] = '{1'b1, 23'd20, 32'h0,         1'b0, 32'hdead_0000, 3};
    vecs[4] = '{1'b0, 23'd40, 32'h1111_2222, 1'b0, 32'hdead_0000, 3};
    vecs[5] = '{1'b1, 23'd3,  32'h0,         1'b1, 32'hdead_0000, 12};
    vecs[6] = '{1'b1, 23'd0,  32'h0,         1'b0, 32'h0000_0000, 3};
    rd3     = vecs[0];

    reset = 1'b1;
    core_reg_req = 1'b0; core_reg_rd_wr_L = 1'b0; core_reg_addr = '0; core_reg_wr_data = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stale return after timeout is ignored; next read is correct
    run_vec(vecs[5], "stale_to");
    repeat (5) tick();
    inject(2'd0, 1'b1, 32'hffff_ffff);
    tick();
    clear_inject();
    check("stale_idle", {31'd0, core_reg_ack, core_reg_rd_data}, {31'd0, 1'b0, 32'hdead_0000});
    run_vec(rd3, "after_stale");

    // Foreign source ignored in WAIT, true return 3 cycles later completes
    ring_broken = 1'b1;
    tick();
    core_reg_rd_wr_L = 1'b1; core_reg_addr = 23'd7; core_reg_req = 1'b1;
    tick(); tick();
    inject(2'd1, 1'b1, 32'hbad0_bad0);
    tick();
    clear_inject();
    check("foreign_k3", 64'(core_reg_ack), 64'd0);
    tick();
    check("foreign_k4", 64'(core_reg_ack), 64'd0);
    tick();
    inject(2'd0, 1'b1, 32'habcd_0001);
    tick();
    clear_inject();
    check("foreign_true", {31'd0, core_reg_ack, core_reg_rd_data}, {31'd0, 1'b1, 32'habcd_0001});
    core_reg_req = 1'b0;
    tick();
    check("foreign_fall", 64'(core_reg_ack), 64'd0);

    // Match and timeout in the same cycle: returned data wins
    tick();
    core_reg_req = 1'b1;
    for (int k = 1; k <= 11; k++) tick();
    check("tie_pre", 64'(core_reg_ack), 64'd0);
    inject(2'd0, 1'b1, 32'h5a5a_a5a5);
    tick();
    clear_inject();
    check("tie_win", {31'd0, core_reg_ack, core_reg_rd_data}, {31'd0, 1'b1, 32'h5a5a_a5a5});
    core_reg_req = 1'b0;
    tick();
    ring_broken = 1'b0;

    // Reset mid-WAIT, late return ignored, next request normal
    ring_broken = 1'b1;
    core_reg_rd_wr_L = 1'b0; core_reg_addr = 23'd9; core_reg_wr_data = 32'h7777_8888;
    core_reg_req = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_all_zero("midwait_rst");
    reset = 1'b0;
    core_reg_req = 1'b0;
    inject(2'd0, 1'b1, 32'hffff_0000);
    tick();
    clear_inject();
    tick();
    check("late_after_rst", {31'd0, core_reg_ack, core_reg_rd_data}, 64'd0);
    ring_broken = 1'b0;
    run_vec(rd3, "after_rst");

    // Hold request past ack; stale return in DONE leaves data alone
    tick();
    core_reg_rd_wr_L = 1'b1; core_reg_addr = 23'd3; core_reg_req = 1'b1;
    repeat (3) tick();
    check("hold_ack_rise", {31'd0, core_reg_ack, core_reg_rd_data}, {31'd0, 1'b1, 32'h1234_5678});
    for (int h = 1; h <= 4; h++) begin
      tick();
      clear_inject();
      check($sformatf("hold%0d", h), {30'd0, core_reg_ack, reg_req_out, core_reg_rd_data},
            {30'd0, 1'b1, 1'b0, 32'h1234_5678});
      if (h == 1) inject(2'd0, 1'b1, 32'h0bad_0bad);
    end
    core_reg_req = 1'b0;
    tick();
    check("hold_fall", {62'd0, core_reg_ack, reg_req_out}, 64'd0);
    tick();
    check("hold_idle", {62'd0, core_reg_ack, reg_req_out}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
